// File: rtl/vm2413_pkg.sv
// ============================================================================
// vm2413_pkg : shared channel/sample types for the vm2413 operator datapath
// Rev 1.0
// ============================================================================
`default_nettype none

package vm2413_pkg;

    localparam int NUM_CH = 9;

    typedef logic [3:0]        CH_TYPE;
    typedef logic signed [9:0] SIGNED_LI_TYPE;

endpackage

`default_nettype wire

// File: rtl/fbgen_history.sv
// ============================================================================
// fbgen_history : per-channel modulator history with post-reset clear sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module fbgen_history
    import vm2413_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  CH_TYPE        rd_addr,
    output SIGNED_LI_TYPE rd_data,
    input  logic          wr_en,
    input  CH_TYPE        wr_addr,
    input  SIGNED_LI_TYPE wr_data,
    output logic          busy
);

    localparam CH_TYPE C_NUM_CH  = CH_TYPE'(NUM_CH);
    localparam CH_TYPE C_LAST_CH = CH_TYPE'(NUM_CH - 1);

    SIGNED_LI_TYPE r_mem [NUM_CH];
    CH_TYPE        r_clr_addr;
    logic          r_busy;

    // The array itself is never reset; the sequencer zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy     <= 1'b1;
            r_clr_addr <= '0;
        end else if (r_busy) begin
            r_mem[r_clr_addr] <= '0;
            if (r_clr_addr == C_LAST_CH) begin
                r_busy <= 1'b0;
            end else begin
                r_clr_addr <= r_clr_addr + CH_TYPE'(1);
            end
        end else if (wr_en && (wr_addr < C_NUM_CH)) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Read-before-write: a same-edge write is not visible here, the caller bypasses.
    always_ff @(posedge clk) begin
        rd_data <= (rd_addr < C_NUM_CH) ? r_mem[rd_addr] : '0;
    end

    assign busy = r_busy;

endmodule

`default_nettype wire

// File: rtl/feedback_generator.sv
// ============================================================================
// feedback_generator : averages each modulator sample with the channel's previous
// one for the feedback store and passes carrier samples through. Rev 1.0
// Build option: FBGEN_ROUNDING_EN selects round-half-up instead of floor.
// ============================================================================
`default_nettype none

module feedback_generator
    import vm2413_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          op_valid,
    input  CH_TYPE        op_ch,
    input  logic          op_mod,
    input  SIGNED_LI_TYPE op_data,
    output logic          fb_wr,
    output CH_TYPE        fb_waddr,
    output SIGNED_LI_TYPE fb_wdata,
    output logic          car_valid,
    output CH_TYPE        car_ch,
    output SIGNED_LI_TYPE car_data,
    output logic          busy
);

    localparam CH_TYPE C_NUM_CH = CH_TYPE'(NUM_CH);

    logic          w_hist_busy;
    SIGNED_LI_TYPE w_prev_rd;
    SIGNED_LI_TYPE w_prev;
    logic          w_accept;
    logic          w_fb_wr;
    logic          w_car;
    logic signed [10:0] w_sum;
    logic signed [10:0] w_sum_adj;
    SIGNED_LI_TYPE w_avg;

    logic          r_s1_valid;
    logic          r_s1_mod;
    CH_TYPE        r_s1_ch;
    SIGNED_LI_TYPE r_s1_data;

    logic          r_s2_mod_valid;
    CH_TYPE        r_s2_ch;
    SIGNED_LI_TYPE r_s2_data;

    fbgen_history u_history (
        .clk     (clk),
        .reset   (reset),
        .rd_addr (op_ch),
        .rd_data (w_prev_rd),
        .wr_en   (w_fb_wr),
        .wr_addr (r_s1_ch),
        .wr_data (r_s1_data),
        .busy    (w_hist_busy)
    );

    assign w_accept = op_valid && !w_hist_busy && (op_ch < C_NUM_CH);
    assign w_fb_wr  = r_s1_valid && r_s1_mod;
    assign w_car    = r_s1_valid && !r_s1_mod;

    // The history write of the sample one stage ahead lands on the same edge as
    // this sample's read, so take that value directly.
    assign w_prev = (r_s2_mod_valid && (r_s2_ch == r_s1_ch)) ? r_s2_data : w_prev_rd;

    assign w_sum = $signed({r_s1_data[9], r_s1_data}) + $signed({w_prev[9], w_prev});

`ifdef FBGEN_ROUNDING_EN
    assign w_sum_adj = w_sum + 11'sd1;
`else
    assign w_sum_adj = w_sum;
`endif

    assign w_avg = SIGNED_LI_TYPE'(w_sum_adj >>> 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid     <= 1'b0;
            r_s1_mod       <= 1'b0;
            r_s1_ch        <= '0;
            r_s1_data      <= '0;
            r_s2_mod_valid <= 1'b0;
            r_s2_ch        <= '0;
            r_s2_data      <= '0;
            fb_wr          <= 1'b0;
            fb_waddr       <= '0;
            fb_wdata       <= '0;
            car_valid      <= 1'b0;
            car_ch         <= '0;
            car_data       <= '0;
        end else begin
            r_s1_valid     <= w_accept;
            r_s1_mod       <= op_mod;
            r_s1_ch        <= op_ch;
            r_s1_data      <= op_data;
            r_s2_mod_valid <= w_fb_wr;
            r_s2_ch        <= r_s1_ch;
            r_s2_data      <= r_s1_data;
            fb_wr          <= w_fb_wr;
            car_valid      <= w_car;
            if (w_fb_wr) begin
                fb_waddr <= r_s1_ch;
                fb_wdata <= w_avg;
            end
            if (w_car) begin
                car_ch   <= r_s1_ch;
                car_data <= r_s1_data;
            end
        end
    end

    assign busy = w_hist_busy;

endmodule

`default_nettype wire

// File: doc/feedback_generator.md
FEEDBACK_GENERATOR -- requirements
Module: feedback_generator

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port op_valid, input, 1, operator output sample present this cycle.
REQ-004 SHALL have port op_ch, input, CH_TYPE (4), channel 0..8 of the sample.
REQ-005 SHALL have port op_mod, input, 1: 1 = modulator slot, 0 = carrier slot.
REQ-006 SHALL have port op_data, input, SIGNED_LI_TYPE (10, two's complement), operator output.
REQ-007 SHALL have ports fb_wr (output, 1), fb_waddr (output, CH_TYPE) and fb_wdata (output, SIGNED_LI_TYPE), forming the write port into the feedback store.
REQ-008 SHALL have ports car_valid (output, 1), car_ch (output, CH_TYPE) and car_data (output, SIGNED_LI_TYPE), the registered carrier output toward the channel mixer.
REQ-009 SHALL have port busy, output, 1, high while the post-reset history clear runs.

Function
REQ-010 SHALL hold a 9-entry history array, prev[ch], containing each channel's last modulator op_data.
REQ-011 SHALL use a 2-stage pipeline: S1 registers inputs and reads prev[op_ch]; S2 computes the result and drives the outputs.
REQ-012 SHALL, for a modulator sample, assert fb_wr exactly 2 cycles after op_valid, with fb_waddr = op_ch and fb_wdata = (op_data + prev[op_ch]) / 2, the sum formed at 11 bits and the result shifted arithmetically right by 1.
REQ-013 SHALL update prev[op_ch] := op_data in the same cycle that the corresponding fb_wr is asserted.
REQ-014 SHALL, when S1 and S2 hold the same channel and both are modulator samples, forward S2's op_data as prev for S1; no stale history is permitted.
REQ-015 SHALL, for a carrier sample, assert car_valid 2 cycles after op_valid, with car_ch = op_ch and car_data = op_data unchanged, and leave prev and fb_wr untouched.
REQ-016 SHALL drive fb_wr and car_valid as single-cycle pulses, one per accepted sample; back-to-back samples are accepted every cycle with no stall.
REQ-017 SHALL ignore op_valid when op_ch > 8: no write, no carrier output, no history change.
REQ-018 SHALL ignore op_valid while busy = 1.
REQ-019 SHALL hold fb_waddr, fb_wdata, car_ch and car_data at their last values when the corresponding strobe is low.

Reset
REQ-020 SHALL, on reset, clear all pipeline valids and drive fb_wr = 0, car_valid = 0, fb_waddr = 0, fb_wdata = 0, car_ch = 0, car_data = 0 and busy = 1.
REQ-021 SHALL, after reset deasserts, clear prev[0..8] at one entry per cycle, then drop busy on the 10th cycle.
REQ-022 SHALL, when reset is asserted mid-operation, discard in-flight samples and produce no strobe from them.

Configuration
REQ-023 SHALL round when macro FBGEN_ROUNDING_EN is defined: fb_wdata = (sum + 1) >>> 1.
REQ-024 SHALL truncate toward minus infinity when FBGEN_ROUNDING_EN is undefined: fb_wdata = sum >>> 1.

Structure
REQ-025 SHALL take CH_TYPE, SIGNED_LI_TYPE and the constant NUM_CH = 9 from the shared vm2413 package.
REQ-026 SHALL implement the history array plus the clear sequencer as sub-module fbgen_history (sync read, one write port, init counter).
REQ-027 SHALL keep the averaging arithmetic and the bypass logic in the top module.

Verification
REQ-028 Reset, then wait: busy stays high for 9 cycles after reset falls, then low; no strobes throughout.
REQ-029 Modulator ch 3 with op_data = 100, then ch 3 with 50 in the next cycle: fb_wr pulses carry (3, 50) then (3, 75), proving the bypass.
REQ-030 Modulator ch 0 with -3 after a clear: fb_wdata = -2 under the default build, or -1 when FBGEN_ROUNDING_EN is defined.
REQ-031 Carrier ch 8 with 511: car_valid fires 2 cycles later with (8, 511), fb_wr stays 0, and prev[8] is unchanged.
REQ-032 op_valid with op_ch = 12, and op_valid while busy: no outputs and no history change.
REQ-033 Reset asserted with 2 samples in flight: no strobes follow and history reads all zero after the clear.
